// File: rtl/wb_commit_stage_if.sv
// Bundle of the MEM->WB handshake, long-latency result port, register-file write
// port, forwarding and debug-trace signals of the writeback/commit stage.
interface wb_commit_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32
);
  logic              ws_allowin;
  logic              ms_to_ws_valid;
  logic              ms_gr_we;
  logic [ADDR_W-1:0] ms_dest;
  logic [DATA_W-1:0] ms_result;
  logic [PC_W-1:0]   ms_pc;
  logic              ws_flush;

  logic              ll_valid;
  logic              ll_ready;
  logic [ADDR_W-1:0] ll_dest;
  logic [DATA_W-1:0] ll_data;
  logic [PC_W-1:0]   ll_pc;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic              ws_to_ds_valid;
  logic [ADDR_W-1:0] ws_fwd_dest;
  logic [DATA_W-1:0] ws_fwd_data;

  logic [PC_W-1:0]   debug_wb_pc;
  logic [3:0]        debug_wb_rf_we;
  logic [ADDR_W-1:0] debug_wb_rf_wnum;
  logic [DATA_W-1:0] debug_wb_rf_wdata;

  modport slave (
    output ws_allowin, ll_ready, rf_we, rf_waddr, rf_wdata,
           ws_to_ds_valid, ws_fwd_dest, ws_fwd_data,
           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  ms_to_ws_valid, ms_gr_we, ms_dest, ms_result, ms_pc, ws_flush,
           ll_valid, ll_dest, ll_data, ll_pc
  );

  modport master (
    input  ws_allowin, ll_ready, rf_we, rf_waddr, rf_wdata,
           ws_to_ds_valid, ws_fwd_dest, ws_fwd_data,
           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output ms_to_ws_valid, ms_gr_we, ms_dest, ms_result, ms_pc, ws_flush,
           ll_valid, ll_dest, ll_data, ll_pc
  );
endinterface

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: holds one pipeline instruction, buffers long-latency results
// in a small FIFO and arbitrates both onto the single register-file write port.
module wb_commit_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PC_W     = 32,
  parameter int LL_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  wb_commit_stage_if.slave   bus
);
  localparam int PTR_W = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
  localparam int CNT_W = $clog2(LL_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
  } ll_entry_t;

  // Stage register
  logic              ws_valid;
  logic              ws_gr_we;
  logic [ADDR_W-1:0] ws_dest;
  logic [DATA_W-1:0] ws_result;
  logic [PC_W-1:0]   ws_pc;

  // Long-latency FIFO
  ll_entry_t         ll_mem [LL_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic      ws_wr, ll_full, ll_empty;
  logic      pipe_grant, ll_pop, ll_push, ws_ready_go, ws_allowin;
  ll_entry_t head;

  // Arbitration uses registered state only, so ll_* never reaches rf_* combinationally.
  assign ws_wr       = ws_valid & ws_gr_we & (ws_dest != '0);
  assign ll_full     = (count == CNT_W'(LL_DEPTH));
  assign ll_empty    = (count == '0);
  assign pipe_grant  = ws_wr & ~ll_full;
  assign ll_pop      = ~ll_empty & ~pipe_grant;
  assign ws_ready_go = ~(ws_wr & ll_full);
  assign ws_allowin  = ~ws_valid | ws_ready_go;
  assign ll_push     = bus.ll_valid & ~ll_full;
  assign head        = ll_mem[rd_ptr];

  // NOTE: every output is given a default first so always_comb never infers a latch.
  always_comb begin
    bus.rf_we       = 1'b0;
    bus.rf_waddr    = head.dest;
    bus.rf_wdata    = head.data;
    bus.debug_wb_pc = head.pc;
    if (pipe_grant) begin
      bus.rf_we       = 1'b1;
      bus.rf_waddr    = ws_dest;
      bus.rf_wdata    = ws_result;
      bus.debug_wb_pc = ws_pc;
    end else if (ll_pop) begin
      bus.rf_we = (head.dest != '0);
    end
  end

  assign bus.ws_allowin        = ws_allowin;
  assign bus.ll_ready          = ~ll_full;
  assign bus.ws_to_ds_valid    = ws_valid;
  assign bus.ws_fwd_dest       = ws_wr ? ws_dest : '0;
  assign bus.ws_fwd_data       = ws_result;
  assign bus.debug_wb_rf_we    = {4{bus.rf_we}};
  assign bus.debug_wb_rf_wnum  = bus.rf_waddr;
  assign bus.debug_wb_rf_wdata = bus.rf_wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid  <= 1'b0;
      ws_gr_we  <= 1'b0;
      ws_dest   <= '0;
      ws_result <= '0;
      ws_pc     <= '0;
    end else if (bus.ws_flush) begin
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= bus.ms_to_ws_valid;
      if (bus.ms_to_ws_valid) begin
        ws_gr_we  <= bus.ms_gr_we;
        ws_dest   <= bus.ms_dest;
        ws_result <= bus.ms_result;
        ws_pc     <= bus.ms_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (ll_push)
        wr_ptr <= (wr_ptr == PTR_W'(LL_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (ll_pop)
        rd_ptr <= (rd_ptr == PTR_W'(LL_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (ll_push && !ll_pop)
        count <= count + CNT_W'(1);
      else if (ll_pop && !ll_push)
        count <= count - CNT_W'(1);
    end
  end

  // NOTE: the payload array is deliberately not reset; occupancy is defined solely by
  // the pointers and count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (ll_push)
      ll_mem[wr_ptr] <= '{dest: bus.ll_dest, data: bus.ll_data, pc: bus.ll_pc};
  end
endmodule
